alu_seq: RTL and testbench

Parametrised, registered successor to the datapath's combinational ALU. It adds a start/done handshake, registered status flags (zero, carry, negative, overflow), and an optional iterative shift-add multiplier. It sits between the register file read ports and the write-back mux of the multicycle CPU, and the controller sequences it through `start`/`busy`/`done`.

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 167 ++++++++++++++++
 tb/tb_alu_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - start/done handshake, operand and result bundle for alu_seq
interface alu_seq_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] ri;
  logic [N-1:0] rj;
  logic [2:0]   func;
  logic [N-1:0] out;
  logic         zero;
  logic         carry;
  logic         neg;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
    output start, ri, rj, func,
    input  out, zero, carry, neg, ovf, busy, done
  );

  modport slave (
    input  start, ri, rj, func,
    output out, zero, carry, neg, ovf, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with status flags and start/done handshake
// Optional iterative shift-add multiplier on func 111 when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
  parameter int N = 16
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  logic [N-1:0] out_q, out_d;
  logic         zero_q, zero_d;
  logic         carry_q, carry_d;
  logic         neg_q, neg_d;
  logic         ovf_q, ovf_d;
  logic         done_q, done_d;

  logic [N:0]   sum;
  logic [N:0]   diff;
  logic [N-1:0] res;
  logic         res_carry;
  logic         res_ovf;
  logic         wr_single;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
  localparam int CW = $clog2(N) + 1;

  state_t         state_q, state_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] acc_next;
  logic [CW-1:0]  cnt_q, cnt_d;
`endif

  // Single-cycle result; diff[N] doubles as the borrow and the set-less-than bit.
  always_comb begin
    sum       = {1'b0, bus.ri} + {1'b0, bus.rj};
    diff      = {1'b0, bus.ri} - {1'b0, bus.rj};
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    case (bus.func)
      3'b000: res = bus.ri;
      3'b001: begin
        res       = sum[N-1:0];
        res_carry = sum[N];
        res_ovf   = (bus.ri[N-1] == bus.rj[N-1]) && (sum[N-1] != bus.ri[N-1]);
      end
      3'b010: begin
        res       = diff[N-1:0];
        res_carry = diff[N];
        res_ovf   = (bus.ri[N-1] != bus.rj[N-1]) && (diff[N-1] != bus.ri[N-1]);
      end
      3'b011:  res = bus.ri & bus.rj;
      3'b100:  res = bus.ri | bus.rj;
      3'b101:  res = ~bus.rj;
      3'b110:  res = {{(N-1){1'b0}}, diff[N]};
      default: res = '0;
    endcase
  end

  always_comb begin
    out_d     = out_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    wr_single = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.func == 3'b111) begin
            mcand_d  = {{N{1'b0}}, bus.ri};
            mplier_d = bus.rj;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            wr_single = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          out_d   = acc_next[N-1:0];
          zero_d  = (acc_next[N-1:0] == '0);
          carry_d = |acc_next[2*N-1:N];
          neg_d   = acc_next[N-1];
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`else
    wr_single = bus.start;
`endif
    if (wr_single) begin
      out_d   = res;
      zero_d  = (res == '0);
      carry_d = res_carry;
      neg_d   = res[N-1];
      ovf_d   = res_ovf;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      out_q    <= out_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
`ifdef ALU_SEQ_MUL_EN
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.out   = out_q;
  assign bus.zero  = zero_q;
  assign bus.carry = carry_q;
  assign bus.neg   = neg_q;
  assign bus.ovf   = ovf_q;
  assign bus.done  = done_q;
`ifdef ALU_SEQ_MUL_EN
  assign bus.busy  = (state_q == S_MUL);
`else
  assign bus.busy  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed vector bench for alu_seq (N = 16), both ALU_SEQ_MUL_EN builds
module tb_alu_seq;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_seq_if #(.N(16)) bus ();

  alu_seq #(.N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  func;
    logic [15:0] ri;
    logic [15:0] rj;
    logic [15:0] exp_out;
    logic        exp_zero;
    logic        exp_carry;
    logic        exp_neg;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] res_word();
    return {12'h0, bus.out, bus.zero, bus.carry, bus.neg, bus.ovf};
  endfunction

  function automatic logic [31:0] pack(input logic [15:0] o, input logic z, input logic c,
                                       input logic n, input logic v);
    return {12'h0, o, z, c, n, v};
  endfunction

  // Launch an op at the next rising edge; returns #1 after that edge with start dropped.
  task automatic issue(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.func  = f;
    bus.ri    = a;
    bus.rj    = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic add_vec(input string nm, input logic [2:0] f, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] o, input logic z,
                         input logic c, input logic n, input logic v);
    vec_t t;
    t.name = nm; t.func = f; t.ri = a; t.rj = b; t.exp_out = o;
    t.exp_zero = z; t.exp_carry = c; t.exp_neg = n; t.exp_ovf = v;
    vecs.push_back(t);
  endtask

  initial begin
    logic saw_done;
    n_vec = 0;
    n_err = 0;

    add_vec("add_small",  3'b001, 16'h0003, 16'h0004, 16'h0007, 0, 0, 0, 0);
    add_vec("add_ovf",    3'b001, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 1);
    add_vec("add_wrap",   3'b001, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0);
    add_vec("add_negneg", 3'b001, 16'h8000, 16'h8000, 16'h0000, 1, 1, 0, 1);
    add_vec("sub_borrow", 3'b010, 16'h0002, 16'h0005, 16'hFFFD, 0, 1, 1, 0);
    add_vec("sub_equal",  3'b010, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0, 0);
    add_vec("sub_ovf",    3'b010, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1);
    add_vec("slt_true",   3'b110, 16'h0002, 16'h0005, 16'h0001, 0, 0, 0, 0);
    add_vec("slt_false",  3'b110, 16'h0005, 16'h0002, 16'h0000, 1, 0, 0, 0);
    add_vec("slt_unsign", 3'b110, 16'h0001, 16'hFFFF, 16'h0001, 0, 0, 0, 0);
    add_vec("and",        3'b011, 16'h0F0F, 16'h00FF, 16'h000F, 0, 0, 0, 0);
    add_vec("or",         3'b100, 16'h0F00, 16'h00F0, 16'h0FF0, 0, 0, 0, 0);
    add_vec("not_rj",     3'b101, 16'h1234, 16'h00FF, 16'hFF00, 0, 0, 1, 0);
    add_vec("pass",       3'b000, 16'h8001, 16'hFFFF, 16'h8001, 0, 0, 1, 0);

    bus.start = 1'b0;
    bus.func  = 3'b000;
    bus.ri    = '0;
    bus.rj    = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(3'b001, 16'h1111, 16'h2222);
    check("pre_reset_out", {16'h0, bus.out}, 32'h3333);

    // Asynchronous reset mid-cycle, away from any edge.
    #2;
    rst = 1'b1;
    #1;
    check("reset_outputs", {25'h0, bus.out != 16'h0, bus.zero, bus.carry, bus.neg, bus.ovf,
                            bus.busy, bus.done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].func, vecs[i].ri, vecs[i].rj);
      check({vecs[i].name, "_res"}, res_word(),
            pack(vecs[i].exp_out, vecs[i].exp_zero, vecs[i].exp_carry, vecs[i].exp_neg,
                 vecs[i].exp_ovf));
      check({vecs[i].name, "_done"}, {31'h0, bus.done}, 32'h1);
    end
    @(posedge clk);
    #1;
    check("done_falls", {31'h0, bus.done}, 32'h0);

    // Start held high re-issues every cycle with the inputs present at each edge.
    @(negedge clk);
    bus.start = 1'b1; bus.func = 3'b001; bus.ri = 16'h0001; bus.rj = 16'h0001;
    @(posedge clk);
    #1;
    check("held_1", {15'h0, bus.out, bus.done}, {15'h0, 16'h0002, 1'b1});
    bus.ri = 16'h0005;
    @(posedge clk);
    #1;
    check("held_2", {15'h0, bus.out, bus.done}, {15'h0, 16'h0006, 1'b1});
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("held_release", {15'h0, bus.out, bus.done}, {15'h0, 16'h0006, 1'b0});

`ifdef ALU_SEQ_MUL_EN
    issue(3'b111, 16'h1000, 16'h0010);
    saw_done = 1'b0;
    for (int i = 0; i < 40 && !saw_done; i++) begin
      @(posedge clk);
      #1;
      saw_done = bus.done;
    end
    check("mul_big_done", {31'h0, saw_done}, 32'h1);
    check("mul_big_res", res_word(), pack(16'h0000, 1, 1, 0, 0));

    issue(3'b111, 16'h0012, 16'h0034);
    check("mul_busy_t", {30'h0, bus.busy, bus.done}, {30'h0, 2'b10});
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        bus.start = 1'b1; bus.func = 3'b001; bus.ri = 16'h00AA; bus.rj = 16'h0001;
      end
      if (k == 5) bus.start = 1'b0;
      @(posedge clk);
      #1;
      if (k < 16 && (bus.busy !== 1'b1 || bus.done !== 1'b0)) begin
        check("mul_busy_step", {30'h0, bus.busy, bus.done}, {30'h0, 2'b10});
      end
    end
    check("mul_end_hs", {30'h0, bus.busy, bus.done}, {30'h0, 2'b01});
    check("mul_res", res_word(), pack(16'h03A8, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("mul_done_falls", {31'h0, bus.done}, 32'h0);

    issue(3'b111, 16'h0012, 16'h0034);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mul_abort", {15'h0, bus.out, bus.busy, bus.done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("mul_abort_quiet", {31'h0, saw_done}, 32'h0);
`else
    issue(3'b111, 16'h0012, 16'h0034);
    check("mul_off_res", res_word(), pack(16'h0000, 1, 0, 0, 0));
    check("mul_off_hs", {30'h0, bus.busy, bus.done}, {30'h0, 2'b01});
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.done) saw_done = 1'b1;
    end
    check("mul_off_quiet", {31'h0, saw_done}, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_again", {15'h0, bus.out, bus.done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
`endif

    issue(3'b011, 16'h0F0F, 16'h00FF);
    check("and_after_reset", {15'h0, bus.out, bus.done}, {15'h0, 16'h000F, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
